key_event_fifo: RTL and testbench
=================================

# key_event_fifo

Parametrised keypad front end for the DES/LCD entry path. It accepts PS/2 set-2 scan-code bytes and tracks make/break/extended prefixes and Shift state. It turns digit, symbol and control keys into compact key codes and queues them in a first-word-fall-through FIFO with a valid/ready handshake toward the entry/LCD controller. Its improvements over the free-running sample-window decoder:

- true release handling
- typematic-repeat suppression
- inter-byte timeout
- lossless buffering with overflow reporting

## Interface
- FIFO_DEPTH, 8, key FIFO entries; power of two, 2..64
- TIMEOUT_CYCLES, 2_500_000, idle cycles after which a pending prefix is abandoned (50 ms at 50 MHz); must be ≥2
- REPEAT_EN, 0, 1 = forward typematic repeats, 0 = one key code per press
- clk_50  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- scan_code  input  8  received PS/2 byte; sampled only when scan_valid=1
- scan_valid  input  1  one-cycle strobe per received byte
- key_code  output  8  FIFO head; 0xFF when FIFO empty
- key_valid  output  1  FIFO non-empty
- key_ready  input  1  consumer accepts head; pop when key_valid & key_ready
- shift_held  output  1  either Shift key currently down
- fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied entries
- overflow  output  1  sticky: a decoded key was dropped because the FIFO was full
- clr_overflow  input  1  synchronous clear of overflow

## Operation
- Decoder FSM states:
  - IDLE; F0 → BRK; E0 → EXT; any other byte → decode as make.
  - BRK: next byte is a release → IDLE.
  - EXT: F0 → EXT_BRK; any other byte is ignored → IDLE.
  - EXT_BRK: next byte is ignored → IDLE.
- Make decode (IDLE):
  - 45,16,1E,26,25,2E,36,3D,3E,46 → 0x00..0x09.
  - With shift_held=1: 26 → 0x0A (#), 3E → 0x0B (*). Other digits with Shift are ignored.
  - 29 (space) → 0x0D clear; 66 (backspace) → 0x0C; 5A (enter) → 0x0E.
  - 12/59 set left/right shift flag and produce no key.
  - All other codes are ignored.
- Release (BRK): 12/59 clear the matching shift flag. shift_held = left | right.
  - If the byte equals held_code, held_code ← 0x00 (none).
- Repeat suppression (REPEAT_EN=0): a decodable make equal to held_code produces nothing. Otherwise it is pushed and held_code ← byte.
  - A different key pressed while one is held replaces held_code.
  - REPEAT_EN=1: every decodable make is pushed.
- Timeout counter:
  - Cleared on every scan_valid.
  - While in BRK/EXT/EXT_BRK it increments. Reaching TIMEOUT_CYCLES forces IDLE; the next byte is treated as fresh.
  - Counter saturates, no wrap. Shift flags and held_code are unaffected.
- FIFO:
  - Circular, read/write pointers of $clog2(FIFO_DEPTH) bits wrap modulo depth.
  - Push when full and no pop in the same cycle: entry dropped, overflow ← 1, contents unchanged.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop when empty: the push lands, nothing is popped, count → 1.
- overflow: set has priority over clr_overflow in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - FSM = IDLE, shift flags 0, held_code 0x00, timeout counter 0.
  - Pointers 0, fifo_count 0, key_valid 0, key_code 0xFF, overflow 0, shift_held 0.
- Byte strobed at edge N: FSM, shift_held and held_code update at edge N; the FIFO write occurs at edge N.
  - key_valid/key_code are visible after edge N (1-cycle latency from strobe).
- Pop at edge M: the next head (or 0xFF) is visible after edge M.
  - key_code and key_valid are stable while key_valid & !key_ready.
- At most one push per cycle. Back-to-back scan_valid every cycle is supported.
- Reset mid-sequence (e.g. in BRK) discards the prefix and all queued keys.

## Test plan
- Press/release "7": 3D, F0, 3D → exactly one key 0x07. key_valid high one cycle after the 3D strobe; fifo_count 1; after pop, key_code 0xFF.
- Shift symbol: 12, 26, F0 26, F0 12, 3E → keys 0x0A then 0x08. shift_held 1 from the first byte to the F0 12 release.
- Repeat: REPEAT_EN=0, 16 ×4 then F0 16 then 16 → keys 0x01, 0x01 (two). REPEAT_EN=1 same stimulus → five 0x01.
- Extended/timeout:
  - E0, 5A → nothing queued.
  - F0 then idle TIMEOUT_CYCLES then 45 → key 0x00 (the 45 is not taken as a release).
- Overflow: key_ready=0, push FIFO_DEPTH+1 digits → fifo_count=FIFO_DEPTH, overflow=1, the first FIFO_DEPTH keys drain in order. Push and pop in the same cycle while full → count stays FIFO_DEPTH, overflow unchanged. clr_overflow → overflow 0.
- Async reset asserted between F0 and the next byte → all outputs at reset values immediately; after release, 1E → key 0x02.

Source files
------------

// File: rtl/key_event_fifo.sv
// key_event_fifo
//
// PS/2 set-2 keypad front end for the DES/LCD entry path. Received scan-code
// bytes go through a small prefix decoder that handles the make, break (F0)
// and extended (E0) prefixes, and tracks the Shift state. Digit, symbol and
// control keys become compact key codes. These codes are queued in a
// first-word-fall-through FIFO that the entry/LCD controller drains.
//
// Handshake: a key is transferred on every rising clk_50 edge where
// key_valid & key_ready are both high. key_valid depends only on the FIFO
// state, never on key_ready. key_code and key_valid stay stable while
// key_valid is high and key_ready is low. When the FIFO is empty, key_code
// reads 0xFF.
//
// Ports:
//   clk_50        system clock (50 MHz)
//   rst_n         asynchronous active-low reset
//   scan_code     received PS/2 byte, sampled when scan_valid = 1
//   scan_valid    one-cycle strobe per received byte
//   key_code      FIFO head (0xFF when empty)
//   key_valid     FIFO non-empty
//   key_ready     consumer accepts head
//   shift_held    left or right Shift currently down
//   fifo_count    occupied FIFO entries
//   overflow      sticky: a decoded key was dropped on a full FIFO
//   clr_overflow  synchronous clear of overflow (set wins)
//   dbg_state     decoder state (0 IDLE, 1 BRK, 2 EXT, 3 EXT_BRK)

module key_event_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int REPEAT_EN      = 0
) (
    input  logic                              clk_50,
    input  logic                              rst_n,
    input  logic [7:0]                        scan_code,
    input  logic                              scan_valid,
    output logic [7:0]                        key_code,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic                              shift_held,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    input  logic                              clr_overflow,
    output logic [1:0]                        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t            state;
    logic              shift_l;
    logic              shift_r;
    logic [7:0]        held_code;
    logic [TO_W-1:0]   to_cnt;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              dec_ok;
    logic [7:0]        dec_code;
    logic              is_repeat;
    logic              push_req;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;

    // ------------------------------------------------------------------
    // Make-code decode. Uses the Shift state from before this byte. Shift
    // bytes themselves are not decodable, so this is never ambiguous.
    // ------------------------------------------------------------------
    always_comb begin
        dec_ok   = 1'b0;
        dec_code = 8'h00;
        case (scan_code)
            8'h45: begin dec_ok = !shift_held; dec_code = 8'h00; end
            8'h16: begin dec_ok = !shift_held; dec_code = 8'h01; end
            8'h1E: begin dec_ok = !shift_held; dec_code = 8'h02; end
            8'h26: begin dec_ok = 1'b1; dec_code = shift_held ? 8'h0A : 8'h03; end
            8'h25: begin dec_ok = !shift_held; dec_code = 8'h04; end
            8'h2E: begin dec_ok = !shift_held; dec_code = 8'h05; end
            8'h36: begin dec_ok = !shift_held; dec_code = 8'h06; end
            8'h3D: begin dec_ok = !shift_held; dec_code = 8'h07; end
            8'h3E: begin dec_ok = 1'b1; dec_code = shift_held ? 8'h0B : 8'h08; end
            8'h46: begin dec_ok = !shift_held; dec_code = 8'h09; end
            8'h66: begin dec_ok = 1'b1; dec_code = 8'h0C; end
            8'h29: begin dec_ok = 1'b1; dec_code = 8'h0D; end
            8'h5A: begin dec_ok = 1'b1; dec_code = 8'h0E; end
            default: begin dec_ok = 1'b0; dec_code = 8'h00; end
        endcase
    end

    assign is_repeat = (REPEAT_EN == 0) && (scan_code == held_code);
    assign push_req  = scan_valid && (state == ST_IDLE) && dec_ok && !is_repeat;

    // ------------------------------------------------------------------
    // Prefix decoder, Shift flags, held key and inter-byte timeout.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            held_code <= 8'h00;
            to_cnt    <= '0;
        end else if (scan_valid) begin
            to_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state <= ST_BRK;
                    end else if (scan_code == 8'hE0) begin
                        state <= ST_EXT;
                    end else begin
                        if (scan_code == 8'h12) shift_l <= 1'b1;
                        if (scan_code == 8'h59) shift_r <= 1'b1;
                        // A new key replaces whatever was held, even when
                        // the FIFO cannot take it.
                        if (dec_ok && !is_repeat) held_code <= scan_code;
                    end
                end
                ST_BRK: begin
                    if (scan_code == 8'h12) shift_l <= 1'b0;
                    if (scan_code == 8'h59) shift_r <= 1'b0;
                    if (scan_code == held_code) held_code <= 8'h00;
                    state <= ST_IDLE;
                end
                ST_EXT: begin
                    state <= (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE) begin
            // Saturating count. The increment that reaches TIMEOUT_CYCLES
            // also abandons the pending prefix.
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_LAST) state <= ST_IDLE;
        end
    end

    assign shift_held = shift_l | shift_r;
    assign dbg_state  = state;

    // ------------------------------------------------------------------
    // FIFO. A pop only happens when non-empty, so a push into an empty
    // FIFO together with key_ready just lands.
    // ------------------------------------------------------------------
    assign key_valid = (count != '0);
    assign pop       = key_valid && key_ready;
    assign full      = (count == DEPTH_C);
    assign do_push   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk_50) begin
        if (do_push) mem[wr_ptr] <= dec_code;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign key_code   = key_valid ? mem[rd_ptr] : 8'hFF;
    assign fifo_count = count;

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo. Two instances share the scan-byte stream:
// dut (REPEAT_EN=0, key_ready driven by the stimulus) and dut_r (REPEAT_EN=1,
// always ready). Each instance has its own expected-key queue. A per-instance
// monitor pops the queue and compares on every accepted handshake.

module tb_key_event_fifo;

    localparam int TB_DEPTH = 4;
    localparam int TB_TO    = 20;
    localparam int CW       = $clog2(TB_DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    always #10 clk_50 = ~clk_50;

    logic [7:0]    scan_code    = 8'h00;
    logic          scan_valid   = 1'b0;
    logic          key_ready    = 1'b0;
    logic          clr_overflow = 1'b0;

    logic [7:0]    key_code,   key_code_r;
    logic          key_valid,  key_valid_r;
    logic          shift_held, shift_held_r;
    logic [CW-1:0] fifo_count, fifo_count_r;
    logic          overflow,   overflow_r;
    logic [1:0]    dbg_state,  dbg_state_r;
    logic          key_ready_r = 1'b1;

    key_event_fifo #(.FIFO_DEPTH(TB_DEPTH), .TIMEOUT_CYCLES(TB_TO), .REPEAT_EN(0)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .shift_held(shift_held), .fifo_count(fifo_count), .overflow(overflow),
        .clr_overflow(clr_overflow), .dbg_state(dbg_state)
    );

    key_event_fifo #(.FIFO_DEPTH(TB_DEPTH), .TIMEOUT_CYCLES(TB_TO), .REPEAT_EN(1)) dut_r (
        .clk_50(clk_50), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .key_code(key_code_r), .key_valid(key_valid_r), .key_ready(key_ready_r),
        .shift_held(shift_held_r), .fifo_count(fifo_count_r), .overflow(overflow_r),
        .clr_overflow(clr_overflow), .dbg_state(dbg_state_r)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_r_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50) begin
        if (rst_n && key_valid && key_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL main_pop: got key %02h, expected no key", key_code);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    fails++;
                    $display("FAIL main_pop: got key %02h, expected %02h", key_code, e);
                end
            end
        end
    end

    always @(negedge clk_50) begin
        if (rst_n && key_valid_r && key_ready_r) begin
            tests++;
            if (exp_r_q.size() == 0) begin
                fails++;
                $display("FAIL rep_pop: got key %02h, expected no key", key_code_r);
            end else begin
                logic [7:0] e;
                e = exp_r_q.pop_front();
                if (key_code_r !== e) begin
                    fails++;
                    $display("FAIL rep_pop: got key %02h, expected %02h", key_code_r, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        tick(1);
        scan_valid = 1'b0;
    endtask

    task automatic expect_both(input logic [7:0] k);
        exp_q.push_back(k);
        exp_r_q.push_back(k);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #25;
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 8'hFF);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_shift", shift_held, 0);
        check("rst_state", dbg_state, 0);
        #10 rst_n = 1'b1;
        tick(1);

        // Press/release "7"
        key_ready = 1'b0;
        expect_both(8'h07);
        send(8'h3D);
        check("t7_valid", key_valid, 1);
        check("t7_code", key_code, 8'h07);
        check("t7_count", fifo_count, 1);
        send(8'hF0);
        check("t7_brk_state", dbg_state, 1);
        send(8'h3D);
        check("t7_count_after_rel", fifo_count, 1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("t7_empty_code", key_code, 8'hFF);
        check("t7_empty_valid", key_valid, 0);

        // Shift symbols
        key_ready = 1'b1;
        send(8'h12);
        check("sh_on", shift_held, 1);
        expect_both(8'h0A);
        send(8'h26);
        send(8'hF0);
        send(8'h26);
        check("sh_still_on", shift_held, 1);
        send(8'hF0);
        check("sh_before_rel", shift_held, 1);
        send(8'h12);
        check("sh_off", shift_held, 0);
        expect_both(8'h08);
        send(8'h3E);
        tick(2);

        // Typematic repeat: main gets one key per press, dut_r every make
        expect_both(8'h01);
        for (int i = 0; i < 3; i++) exp_r_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) send(8'h16);
        send(8'hF0);
        send(8'h16);
        expect_both(8'h01);
        send(8'h16);
        tick(2);

        // Extended prefix: E0 5A queues nothing
        key_ready = 1'b0;
        send(8'hE0);
        check("ext_state", dbg_state, 2);
        send(8'h5A);
        check("ext_idle", dbg_state, 0);
        tick(2);
        check("ext_count", fifo_count, 0);
        check("ext_valid", key_valid, 0);

        // Timeout of a dangling F0
        key_ready = 1'b1;
        send(8'hF0);
        tick(TB_TO - 1);
        check("to_still_brk", dbg_state, 1);
        tick(1);
        check("to_idle", dbg_state, 0);
        expect_both(8'h00);
        send(8'h45);
        tick(2);

        // Overflow: 5 digits into a 4-deep FIFO
        key_ready = 1'b0;
        expect_both(8'h02); send(8'h1E);
        expect_both(8'h03); send(8'h26);
        expect_both(8'h04); send(8'h25);
        expect_both(8'h05); send(8'h2E);
        exp_r_q.push_back(8'h06); send(8'h36);
        check("ovf_count", fifo_count, TB_DEPTH);
        check("ovf_set", overflow, 1);
        check("ovf_head", key_code, 8'h02);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);
        // push and pop together while full
        key_ready = 1'b1;
        expect_both(8'h07);
        send(8'h3D);
        key_ready = 1'b0;
        check("pp_count", fifo_count, TB_DEPTH);
        check("pp_ovf", overflow, 0);
        check("pp_head", key_code, 8'h03);
        // drop while clearing: set wins
        clr_overflow = 1'b1;
        exp_r_q.push_back(8'h09);
        send(8'h46);
        clr_overflow = 1'b0;
        check("ovf_set_wins", overflow, 1);
        check("ovf_count2", fifo_count, TB_DEPTH);
        key_ready = 1'b1;
        tick(6);
        check("drain_code", key_code, 8'hFF);
        check("drain_count", fifo_count, 0);
        check("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_clr2", overflow, 0);

        // Async reset between F0 and the next byte
        key_ready = 1'b0;
        expect_both(8'h01);
        send(8'h16);
        send(8'h12);
        send(8'hF0);
        check("pre_rst_shift", shift_held, 1);
        check("pre_rst_count", fifo_count, 1);
        check("pre_rst_state", dbg_state, 1);
        #4 rst_n = 1'b0;
        #1;
        check("ar_valid", key_valid, 0);
        check("ar_code", key_code, 8'hFF);
        check("ar_count", fifo_count, 0);
        check("ar_shift", shift_held, 0);
        check("ar_state", dbg_state, 0);
        check("ar_ovf", overflow, 0);
        exp_q.delete();
        exp_r_q.delete();
        #2 rst_n = 1'b1;
        tick(1);
        key_ready = 1'b1;
        expect_both(8'h02);
        send(8'h1E);
        tick(3);

        check("end_main_q", exp_q.size(), 0);
        check("end_rep_q", exp_r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
